// File: rtl/ysyx_22051145_ifstage.sv
// rtl/ysyx_22051145_ifstage.sv - RV64 instruction-fetch stage with a 2-entry fetch buffer
// Optional feature macro: IF_MISALIGN_EXC_EN (misaligned redirect targets become exception entries).
module ysyx_22051145_ifstage #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        req_valid,
    output logic [63:0] req_addr,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [31:0] resp_inst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_o,
    output logic [63:0] pc_o,
    output logic        exc_o,
    input  logic        inst_ready
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic [63:0] pc;
    logic [1:0]  outstanding;
    logic [1:0]  drop_cnt;
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] fifo_inst [2];
    logic [63:0] fifo_pc   [2];
    logic [63:0] iq_pc     [2];
    logic        iq_rd;
    logic        iq_wr;

    logic [2:0]  occupancy;
    logic        credit;
    logic        fetch_en;
    logic        exc_push;
    logic [63:0] redirect_target;
    logic        req_fire;
    logic        resp_keep;
    logic        push;
    logic        pop;
    logic [31:0] push_inst;
    logic [63:0] push_pc;

    // Every in-flight request owns a FIFO slot, so a response can never overflow the buffer.
    assign occupancy = {1'b0, outstanding} + {1'b0, count};
    assign credit    = occupancy < 3'd2;

`ifdef IF_MISALIGN_EXC_EN
    typedef enum logic [1:0] {S_FETCH, S_EXC_PEND, S_HALT} state_t;

    state_t state;
    state_t state_nxt;
    logic   fifo_exc [2];

    assign redirect_target = redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fetch_en  = 1'b0;
        exc_push  = 1'b0;
        if (redirect_valid) begin
            state_nxt = (redirect_pc[1:0] != 2'b00) ? S_EXC_PEND : S_FETCH;
        end else begin
            case (state)
                S_FETCH:    fetch_en = 1'b1;
                S_EXC_PEND: if (credit) begin
                    exc_push  = 1'b1;
                    state_nxt = S_HALT;
                end
                S_HALT:     state_nxt = S_HALT;
                default:    state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_exc[0] <= 1'b0;
            fifo_exc[1] <= 1'b0;
        end else if (!redirect_valid && push) begin
            fifo_exc[wr_ptr] <= exc_push;
        end
    end

    assign exc_o = inst_valid & fifo_exc[rd_ptr];
`else
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redirect_target     = {redirect_pc[63:2], 2'b00};
    assign fetch_en            = 1'b1;
    assign exc_push            = 1'b0;
    assign exc_o               = 1'b0;
`endif

    assign req_valid = credit & fetch_en & ~redirect_valid;
    assign req_addr  = pc;
    assign req_fire  = req_valid & req_ready;

    // Responses that were in flight across a redirect are counted off by drop_cnt.
    assign resp_keep = resp_valid & ~redirect_valid & (drop_cnt == 2'd0);
    assign push      = resp_keep | exc_push;
    assign push_inst = exc_push ? NOP_INST : resp_inst;
    assign push_pc   = exc_push ? pc : iq_pc[iq_rd];

    assign inst_valid = (count != 2'd0);
    assign pop        = inst_valid & inst_ready & ~redirect_valid;
    assign inst_o     = inst_valid ? fifo_inst[rd_ptr] : 32'd0;
    assign pc_o       = inst_valid ? fifo_pc[rd_ptr] : 64'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            iq_rd       <= 1'b0;
            iq_wr       <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_inst[i] <= 32'd0;
                fifo_pc[i]   <= 64'd0;
                iq_pc[i]     <= 64'd0;
            end
        end else begin
            if (redirect_valid)  pc <= redirect_target;
            else if (req_fire)   pc <= pc + 64'd4;

            outstanding <= outstanding + {1'b0, req_fire} - {1'b0, resp_valid};

            if (req_fire) begin
                iq_pc[iq_wr] <= pc;
                iq_wr        <= ~iq_wr;
            end
            if (resp_valid) iq_rd <= ~iq_rd;

            if (redirect_valid)
                drop_cnt <= outstanding - {1'b0, resp_valid};
            else if (resp_valid && drop_cnt != 2'd0)
                drop_cnt <= drop_cnt - 2'd1;

            if (redirect_valid) begin
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) begin
                    fifo_inst[wr_ptr] <= push_inst;
                    fifo_pc[wr_ptr]   <= push_pc;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22051145_ifstage.sv
// tb/tb_ysyx_22051145_ifstage.sv - self-checking bench for ysyx_22051145_ifstage
module tb_ysyx_22051145_ifstage;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int MEM_FIXED = 0;
    localparam int MEM_RAND  = 1;
    localparam int MEM_HOLD  = 2;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        exc;
    } pop_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready = 1'b0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_inst = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        inst_valid;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        exc_o;
    logic        inst_ready = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          mem_mode = MEM_FIXED;
    logic [63:0] mem_q[$];
    logic [63:0] req_log[$];
    pop_t        pop_log[$];
    logic        s_req_valid;
    logic        s_inst_valid;

    ysyx_22051145_ifstage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_inst     (resp_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .exc_o         (exc_o),
        .inst_ready    (inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ {a[9:2], a[17:10], a[25:18], a[33:26]} ^ 32'h5A00_00C3;
    endfunction

    // Memory model: in-order, responds no earlier than the cycle after acceptance.
    task automatic tick();
        logic        rf;
        logic        vf;
        logic [63:0] ra;
        pop_t        e;
        resp_valid = 1'b0;
        resp_inst  = 32'd0;
        if (mem_q.size() > 0 &&
            (mem_mode == MEM_FIXED || (mem_mode == MEM_RAND && $urandom_range(0, 2) != 0))) begin
            resp_valid = 1'b1;
            resp_inst  = inst_of(mem_q[0]);
        end
        #1;
        s_req_valid  = req_valid;
        s_inst_valid = inst_valid;
        rf = req_valid & req_ready;
        ra = req_addr;
        vf = resp_valid;
        if (rf) req_log.push_back(ra);
        if (inst_valid && inst_ready && !redirect_valid) begin
            e.pc = pc_o; e.inst = inst_o; e.exc = exc_o;
            pop_log.push_back(e);
        end
        @(posedge clk);
        if (vf) void'(mem_q.pop_front());
        if (rf) mem_q.push_back(ra);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_inst = 32'd0;
        redirect_valid = 1'b0; redirect_pc = 64'd0; inst_ready = 1'b0;
        mem_mode = MEM_FIXED;
        mem_q.delete(); req_log.delete(); pop_log.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (int'(dut.outstanding) + int'(dut.count) > 2) begin
                errors++;
                $display("FAIL occupancy: outstanding+count=%0d, required <= 2",
                         int'(dut.outstanding) + int'(dut.count));
            end
        end
    end

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL reset_req_valid: got %b want 1", req_valid); end
        checks++; if (req_addr !== RESET_PC) begin errors++; $display("FAIL reset_req_addr: got %h want %h", req_addr, RESET_PC); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        checks++; if (inst_o !== 32'd0) begin errors++; $display("FAIL reset_inst_o: got %h want 0", inst_o); end
        checks++; if (pc_o !== 64'd0) begin errors++; $display("FAIL reset_pc_o: got %h want 0", pc_o); end
        checks++; if (exc_o !== 1'b0) begin errors++; $display("FAIL reset_exc_o: got %b want 0", exc_o); end
    endtask

    task automatic test_stream();
        logic [63:0] exp_pc = RESET_PC;
        logic [63:0] exp_req = RESET_PC;
        logic [63:0] a;
        pop_t        e;
        int          n = 0;
        req_ready = 1'b1; inst_ready = 1'b1; mem_mode = MEM_FIXED;
        repeat (30) begin
            tick();
            while (req_log.size() > 0) begin
                a = req_log.pop_front();
                checks++; if (a !== exp_req) begin errors++; $display("FAIL stream_req_addr: got %h want %h", a, exp_req); end
                exp_req += 64'd4;
            end
            while (pop_log.size() > 0) begin
                e = pop_log.pop_front();
                checks++;
                if (e.pc !== exp_pc || e.inst !== inst_of(exp_pc) || e.exc !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_pop: got pc=%h inst=%h exc=%b want pc=%h inst=%h exc=0",
                             e.pc, e.inst, e.exc, exp_pc, inst_of(exp_pc));
                end
                exp_pc += 64'd4;
                n++;
            end
        end
        checks++; if (n < 12) begin errors++; $display("FAIL stream_count: got %0d pops want >= 12", n); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_ready = 1'b1; inst_ready = 1'b0;
        repeat (10) tick();
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b want 0", req_valid); end
        checks++; if (mem_q.size() != 0) begin errors++; $display("FAIL bp_outstanding: got %0d want 0", mem_q.size()); end
        checks++; if (dut.count !== 2'd2) begin errors++; $display("FAIL bp_count: got %0d want 2", dut.count); end
        checks++; if (inst_valid !== 1'b1 || pc_o !== RESET_PC || inst_o !== inst_of(RESET_PC)) begin
            errors++; $display("FAIL bp_head: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                               inst_valid, pc_o, inst_o, RESET_PC, inst_of(RESET_PC));
        end
        req_log.delete(); pop_log.delete();
        inst_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (pop_log.size() < 2) begin
            errors++; $display("FAIL bp_drain_count: got %0d want >= 2", pop_log.size());
        end else if (pop_log[0].pc !== RESET_PC || pop_log[1].pc !== RESET_PC + 64'd4 ||
                     pop_log[1].inst !== inst_of(RESET_PC + 64'd4)) begin
            errors++; $display("FAIL bp_drain_order: got %h,%h want %h,%h",
                               pop_log[0].pc, pop_log[1].pc, RESET_PC, RESET_PC + 64'd4);
        end
        checks++;
        if (req_log.size() < 1 || req_log[0] !== RESET_PC + 64'd8) begin
            errors++; $display("FAIL bp_resume_addr: got n=%0d addr=%h want %h", req_log.size(),
                               (req_log.size() > 0) ? req_log[0] : 64'd0, RESET_PC + 64'd8);
        end
    endtask

    task automatic test_redirect(input logic coincident, input logic [63:0] tgt);
        logic found = 1'b0;
        do_reset();
        req_ready = 1'b1; inst_ready = 1'b1; mem_mode = MEM_HOLD;
        repeat (2) tick();
        if (coincident) mem_mode = MEM_FIXED;
        redirect_valid = 1'b1; redirect_pc = tgt;
        tick();
        redirect_valid = 1'b0;
        checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_valid: got %b want 0", s_req_valid); end
        checks++; if (dut.drop_cnt !== (coincident ? 2'd1 : 2'd2)) begin
            errors++; $display("FAIL redir_drop_cnt: got %0d want %0d", dut.drop_cnt, coincident ? 1 : 2);
        end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_stale: got inst_valid=%b want 0", inst_valid); end
        mem_mode = MEM_FIXED;
        pop_log.delete();
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (pop_log.size() > 0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL redir_timeout: got no instruction want pc=%h", tgt);
        end else if (pop_log[0].pc !== tgt || pop_log[0].inst !== inst_of(tgt)) begin
            errors++; $display("FAIL redir_first: got pc=%h inst=%h want pc=%h inst=%h",
                               pop_log[0].pc, pop_log[0].inst, tgt, inst_of(tgt));
        end
    endtask

    task automatic test_misalign();
        do_reset();
        req_ready = 1'b1; inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
        tick();
        redirect_valid = 1'b0;
`ifdef IF_MISALIGN_EXC_EN
        req_log.delete();
        repeat (4) tick();
        checks++; if (req_log.size() != 0) begin errors++; $display("FAIL mis_no_req: got %0d requests want 0", req_log.size()); end
        checks++; if (inst_valid !== 1'b1 || exc_o !== 1'b1 || inst_o !== 32'h0000_0013 || pc_o !== 64'h8000_0002) begin
            errors++; $display("FAIL mis_entry: got v=%b exc=%b inst=%h pc=%h want v=1 exc=1 inst=00000013 pc=0000000080000002",
                               inst_valid, exc_o, inst_o, pc_o);
        end
`else
        #1;
        checks++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_0000) begin
            errors++; $display("FAIL mis_forced_align: got v=%b addr=%h want v=1 addr=0000000080000000", req_valid, req_addr);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        do_reset();
        req_ready = 1'b1; inst_ready = 1'b0;
        repeat (6) tick();
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_full: got %b want 1", inst_valid); end
        rst_n = 1'b0; resp_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mid_async_clear: got %b want 0", inst_valid); end
        mem_q.delete(); req_log.delete(); pop_log.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_valid !== 1'b1 || req_addr !== RESET_PC) begin
            errors++; $display("FAIL mid_restart: got v=%b addr=%h want v=1 addr=%h", req_valid, req_addr, RESET_PC);
        end
    endtask

    task automatic test_random();
        logic [63:0] exp_pc = RESET_PC;
        logic [63:0] exp_req = RESET_PC;
        logic [63:0] tgt;
        logic [63:0] a;
        pop_t        e;
        int          n = 0;
        do_reset();
        mem_mode = MEM_RAND;
        for (int c = 0; c < 3000; c++) begin
            req_ready      = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            tgt            = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4;
            redirect_pc    = tgt;
            tick();
            while (req_log.size() > 0) begin
                a = req_log.pop_front();
                checks++; if (a !== exp_req) begin errors++; $display("FAIL rand_req_addr: cycle %0d got %h want %h", c, a, exp_req); end
                exp_req += 64'd4;
            end
            while (pop_log.size() > 0) begin
                e = pop_log.pop_front();
                checks++;
                if (e.pc !== exp_pc || e.inst !== inst_of(exp_pc) || e.exc !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_pop: cycle %0d got pc=%h inst=%h exc=%b want pc=%h inst=%h exc=0",
                             c, e.pc, e.inst, e.exc, exp_pc, inst_of(exp_pc));
                end
                exp_pc += 64'd4;
                n++;
            end
            if (redirect_valid) begin
                checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL rand_redir_req: cycle %0d got req_valid=%b want 0", c, s_req_valid); end
                exp_pc  = tgt;
                exp_req = tgt;
            end
        end
        redirect_valid = 1'b0;
        checks++; if (n < 200) begin errors++; $display("FAIL rand_progress: got %0d pops want >= 200", n); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect(1'b0, 64'h8000_1000);
        test_redirect(1'b1, 64'h8000_2000);
        test_misalign();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
